// File: rtl/multi_edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-select
// encodings and the counter width helper.
package multi_edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, glitch filter, edge qualification,
// pulse stretcher and sticky status flag.
module edge_channel
    import multi_edge_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter int   PULSE_WIDTH   = 1,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_sig,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       clr_flag,
    output logic       edge_out,
    output logic       edge_is_rise,
    output logic       edge_flag
);

    localparam int PULSE_W = cnt_width(PULSE_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_s;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic [PULSE_W-1:0]     pulse_q, pulse_d;
    logic                   rise_q, rise_d;
    logic                   flag_q, flag_d;
    logic                   is_edge;
    logic                   qualify;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_sig};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after it has persisted FILTER_CYCLES cycles.
    generate
        if (FILTER_CYCLES <= 1) begin : g_no_filter
            always_comb begin
                filt_d = sync_s;
            end
        end else begin : g_filter
            localparam int FILT_W = cnt_width(FILTER_CYCLES);

            logic [FILT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync_s != filt_q) begin
                    if (cnt_q == FILT_W'(FILTER_CYCLES - 1)) begin
                        filt_d = sync_s;
                    end else begin
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        is_edge     = (filt_q != filt_prev_q);
        qualify     = 1'b0;
        filt_prev_d = filt_q;
        if (enable && is_edge) begin
            case (mode)
                MODE_OFF:  qualify = 1'b0;
                MODE_RISE: qualify = filt_q;
                MODE_FALL: qualify = !filt_q;
                MODE_BOTH: qualify = 1'b1;
                default:   qualify = 1'b0;
            endcase
        end

        pulse_d = (pulse_q != '0) ? pulse_q - PULSE_W'(1) : '0;
        rise_d  = rise_q;
        flag_d  = clr_flag ? 1'b0 : flag_q;
        // A new edge retriggers the stretcher and wins over a flag clear.
        if (qualify) begin
            pulse_d = PULSE_W'(PULSE_WIDTH);
            rise_d  = filt_q;
            flag_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= {SYNC_STAGES{INIT_LEVEL}};
            filt_q      <= INIT_LEVEL;
            filt_prev_q <= INIT_LEVEL;
            pulse_q     <= '0;
            rise_q      <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            pulse_q     <= pulse_d;
            rise_q      <= rise_d;
            flag_q      <= flag_d;
        end
    end

    assign edge_out     = (pulse_q != '0);
    assign edge_is_rise = rise_q;
    assign edge_flag    = flag_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: independent per-pin channels whose sticky
// flags are ORed into a single interrupt line.
module multi_edge_detector
    import multi_edge_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter int   PULSE_WIDTH   = 1,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in_sig,
    input  logic                  enable,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr_flag,
    output logic [CHANNELS-1:0]   edge_out,
    output logic [CHANNELS-1:0]   edge_is_rise,
    output logic [CHANNELS-1:0]   edge_flag,
    output logic                  irq
);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            edge_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .PULSE_WIDTH   (PULSE_WIDTH),
                .INIT_LEVEL    (INIT_LEVEL)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .in_sig       (in_sig[i]),
                .enable       (enable),
                .mode         (mode[2*i +: 2]),
                .clr_flag     (clr_flag[i]),
                .edge_out     (edge_out[i]),
                .edge_is_rise (edge_is_rise[i]),
                .edge_flag    (edge_flag[i])
            );
        end
    endgenerate

    assign irq = |edge_flag;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: two instances (filtered and unfiltered)
// checked every cycle against a run-length/timestamp reference model.
module tb_multi_edge_detector;
    import multi_edge_pkg::*;

    localparam int   CH    = 4;
    localparam int   SYNC  = 2;
    localparam logic INIT  = 1'b0;
    localparam int   FC_A  = 3;
    localparam int   PW_A  = 2;
    localparam int   FC_B  = 0;
    localparam int   PW_B  = 4;

    logic clk = 1'b0;
    logic rst;

    logic [CH-1:0]   inSig   [2];
    logic [2*CH-1:0] modeSig [2];
    logic            enSig   [2];
    logic [CH-1:0]   clrSig  [2];

    logic [CH-1:0] outA, riseA, flagA;
    logic [CH-1:0] outB, riseB, flagB;
    logic          irqA, irqB;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state, indexed [dut][channel].
    int            edgeNum  [2];
    logic [CH-1:0] hist     [2][8];
    logic          lastS    [2][CH];
    int            runLen   [2][CH];
    logic          fCur     [2][CH];
    logic          fOld     [2][CH];
    int            lastEdge [2][CH];
    logic          pol      [2][CH];
    logic          flag     [2][CH];

    multi_edge_detector #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC_A),
        .PULSE_WIDTH(PW_A), .INIT_LEVEL(INIT)
    ) dutA (
        .clk(clk), .rst(rst), .in_sig(inSig[0]), .enable(enSig[0]),
        .mode(modeSig[0]), .clr_flag(clrSig[0]), .edge_out(outA),
        .edge_is_rise(riseA), .edge_flag(flagA), .irq(irqA)
    );

    multi_edge_detector #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC_B),
        .PULSE_WIDTH(PW_B), .INIT_LEVEL(INIT)
    ) dutB (
        .clk(clk), .rst(rst), .in_sig(inSig[1]), .enable(enSig[1]),
        .mode(modeSig[1]), .clr_flag(clrSig[1]), .edge_out(outB),
        .edge_is_rise(riseB), .edge_flag(flagB), .irq(irqB)
    );

    always #5 clk = ~clk;

    function automatic int minRun(input int d);
        int fc;
        fc = (d == 0) ? FC_A : FC_B;
        return (fc < 1) ? 1 : fc;
    endfunction

    function automatic int pulseOf(input int d);
        return (d == 0) ? PW_A : PW_B;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset(input int d);
        edgeNum[d] = 0;
        for (int k = 0; k < 8; k++) hist[d][k] = '0;
        for (int c = 0; c < CH; c++) begin
            lastS[d][c]    = INIT;
            runLen[d][c]   = 0;
            fCur[d][c]     = INIT;
            fOld[d][c]     = INIT;
            lastEdge[d][c] = -100;
            pol[d][c]      = 1'b0;
            flag[d][c]     = 1'b0;
        end
    endtask

    // The filter sees the pin value sampled SYNC edges ago; a level is
    // accepted once it has been seen for minRun consecutive edges.
    task automatic modelStep(input int d);
        logic       s, isEdge, isRise, qual;
        logic [1:0] m;
        edgeNum[d]++;
        hist[d][edgeNum[d] % 8] = inSig[d];
        for (int c = 0; c < CH; c++) begin
            s      = (edgeNum[d] > SYNC) ? hist[d][(edgeNum[d] - SYNC) % 8][c] : INIT;
            isEdge = (fCur[d][c] != fOld[d][c]);
            isRise = fCur[d][c];
            m      = modeSig[d][2*c +: 2];
            qual   = enSig[d] && isEdge &&
                     (isRise ? (m == MODE_RISE || m == MODE_BOTH)
                             : (m == MODE_FALL || m == MODE_BOTH));
            if (qual) begin
                lastEdge[d][c] = edgeNum[d];
                pol[d][c]      = isRise;
                flag[d][c]     = 1'b1;
            end else if (clrSig[d][c]) begin
                flag[d][c] = 1'b0;
            end
            fOld[d][c] = fCur[d][c];
            if (s == lastS[d][c]) begin
                runLen[d][c]++;
            end else begin
                lastS[d][c]  = s;
                runLen[d][c] = 1;
            end
            if (runLen[d][c] >= minRun(d)) fCur[d][c] = s;
        end
    endtask

    task automatic checkDut(input int d);
        logic [CH-1:0] expOut, expPol, expFlag, obsOut, obsRise, obsFlag;
        logic          obsIrq;
        for (int c = 0; c < CH; c++) begin
            expOut[c]  = (edgeNum[d] - lastEdge[d][c]) < pulseOf(d);
            expPol[c]  = pol[d][c];
            expFlag[c] = flag[d][c];
        end
        obsOut  = (d == 0) ? outA  : outB;
        obsRise = (d == 0) ? riseA : riseB;
        obsFlag = (d == 0) ? flagA : flagB;
        obsIrq  = (d == 0) ? irqA  : irqB;
        checkOutput($sformatf("dut%0d edge_out", d), obsOut, expOut);
        checkOutput($sformatf("dut%0d edge_is_rise", d), obsRise & expOut, expPol & expOut);
        checkOutput($sformatf("dut%0d edge_flag", d), obsFlag, expFlag);
        checkOutput($sformatf("dut%0d irq", d), obsIrq, |expFlag);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        if (rst) begin
            modelStep(0);
            modelStep(1);
        end
        #1;
        checkDut(0);
        checkDut(1);
        clrSig[0] = '0;
        clrSig[1] = '0;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] inV, input logic [2*CH-1:0] modeV,
                                 input logic enV, input logic [CH-1:0] clrV, input int cycles);
        inSig[0]   = inV;
        modeSig[0] = modeV;
        enSig[0]   = enV;
        clrSig[0]  = clrV;
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " A edge_out"}, outA, '0);
        checkOutput({tag, " A edge_is_rise"}, riseA, '0);
        checkOutput({tag, " A edge_flag"}, flagA, '0);
        checkOutput({tag, " A irq"}, irqA, 1'b0);
        checkOutput({tag, " B edge_out"}, outB, '0);
        checkOutput({tag, " B edge_flag"}, flagB, '0);
        checkOutput({tag, " B irq"}, irqB, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the outputs drop at once.
    task automatic asyncReset(input string tag);
        rst = 1'b0;
        #1;
        checkResetState(tag);
        modelReset(0);
        modelReset(1);
        stepCycle();
        stepCycle();
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        inSig[0]   = 4'hF;
        modeSig[0] = 8'hFF;
        enSig[0]   = 1'b1;
        clrSig[0]  = '0;
        inSig[1]   = 4'h0;
        modeSig[1] = 8'hFF;
        enSig[1]   = 1'b1;
        clrSig[1]  = '0;
        modelReset(0);
        modelReset(1);

        #2;
        checkResetState("resetHold");
        for (int i = 0; i < 3; i++) stepCycle();
        checkResetState("resetHoldClocked");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("resetReleaseEarly", outA, 4'h0);
        stepCycle();
        checkOutput("resetReleasePulse", outA, 4'hF);
        checkOutput("resetReleaseRise", riseA, 4'hF);

        applyStimulus(4'h0, 8'hFF, 1'b1, 4'h0, 12);
        applyStimulus(4'h0, 8'hFD, 1'b1, 4'hF, 4);
        checkOutput("flagsClearedIrq", irqA, 1'b0);
        applyStimulus(4'h1, 8'hFD, 1'b1, 4'h0, 5);
        checkOutput("riseOnlyEarly", outA[0], 1'b0);
        stepCycle();
        checkOutput("riseOnlyPulse1", outA[0], 1'b1);
        checkOutput("riseOnlyPolarity", riseA[0], 1'b1);
        stepCycle();
        checkOutput("riseOnlyPulse2", outA[0], 1'b1);
        checkOutput("riseOnlyFlag", flagA[0], 1'b1);
        checkOutput("riseOnlyIrq", irqA, 1'b1);
        stepCycle();
        checkOutput("riseOnlyPulseEnd", outA[0], 1'b0);
        applyStimulus(4'h0, 8'hFD, 1'b1, 4'h0, 10);

        applyStimulus(4'h0, 8'hFF, 1'b1, 4'hF, 3);
        applyStimulus(4'h2, 8'hFF, 1'b1, 4'h0, 2);
        applyStimulus(4'h0, 8'hFF, 1'b1, 4'h0, 8);
        checkOutput("glitchNoFlag", flagA[1], 1'b0);
        applyStimulus(4'h2, 8'hFF, 1'b1, 4'h0, 3);
        applyStimulus(4'h0, 8'hFF, 1'b1, 4'h0, 12);
        checkOutput("glitchLongFlag", flagA[1], 1'b1);

        applyStimulus(4'h0, 8'hFF, 1'b1, 4'hF, 3);
        applyStimulus(4'h1, 8'hFF, 1'b1, 4'h0, 5);
        applyStimulus(4'h1, 8'hFF, 1'b1, 4'h1, 1);
        checkOutput("flagSetWins", flagA[0], 1'b1);
        applyStimulus(4'h1, 8'hFF, 1'b1, 4'h1, 1);
        checkOutput("flagClear", flagA[0], 1'b0);
        checkOutput("flagClearIrq", irqA, 1'b0);

        applyStimulus(4'h0, 8'hFF, 1'b0, 4'h0, 10);
        checkOutput("disabledNoFlag", flagA, 4'h0);
        checkOutput("disabledNoPulse", outA, 4'h0);
        applyStimulus(4'h0, 8'hFF, 1'b1, 4'h0, 2);

        applyStimulus(4'h8, 8'hFF, 1'b1, 4'h0, 6);
        checkOutput("preResetPulse", outA[3], 1'b1);
        asyncReset("midPulseReset");

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) inSig[1][2] = ~inSig[1][2];
            stepCycle();
            if (i >= 3) checkOutput("retriggerHold", outB[2], 1'b1);
        end

        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0) inSig[d][$urandom_range(0, CH - 1)] ^= 1'b1;
                if ($urandom_range(0, 31) == 0) modeSig[d] = 8'($urandom);
                enSig[d]  = ($urandom_range(0, 7) != 0);
                clrSig[d] = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            end
            if ($urandom_range(0, 399) == 0) begin
                asyncReset("randomReset");
            end else begin
                stepCycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit positive-edge detector.
- Per channel:
  - synchronises an asynchronous input;
  - rejects glitches shorter than a programmable stable time;
  - detects rising, falling or both edges, selected per channel;
  - emits a stretched pulse.
- Keeps a sticky per-channel status flag with clear, ORed into one interrupt line. Sits between raw external pins and control logic or interrupt aggregation.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 3, consecutive cycles a new level must persist before acceptance (0 = no filtering).
- PULSE_WIDTH, 1, edge_out high time in clk cycles (>=1).
- INIT_LEVEL, 0, reset value of the synchroniser and filtered level for all channels.

Ports:
- clk, input, 1, system clock; all state on the rising edge.
- rst, input, 1, reset; asynchronous assert, active-low (0 = reset).
- in_sig, input, CHANNELS, raw asynchronous inputs.
- enable, input, 1, global detect enable.
- mode, input, 2*CHANNELS, per-channel edge select; bits [2i+1:2i] belong to channel i.
- clr_flag, input, CHANNELS, per-channel flag clear, 1-cycle pulse.
- edge_out, output, CHANNELS, stretched edge pulse.
- edge_is_rise, output, CHANNELS, polarity of the last reported edge; valid while edge_out is high.
- edge_flag, output, CHANNELS, sticky "edge seen" status.
- irq, output, 1, OR of all edge_flag bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchroniser and filtered level go to INIT_LEVEL;
  - filter counters, pulse counters, edge_out, edge_is_rise and edge_flag go to 0;
  - irq is 0.
  - The same applies when reset is asserted mid-pulse or mid-filter.
- Reset release is synchronous to clk. If in_sig differs from INIT_LEVEL, the first accepted transition is reported as a normal edge.
- Synchroniser: a SYNC_STAGES-deep shift register per channel. Its last stage is "s".
- Filter, per channel:
  - f is the filtered level; cnt is a counter of width clog2(FILTER_CYCLES+1).
  - If s != f: cnt increments. When cnt reaches FILTER_CYCLES-1 and s != f still holds, f <= s and cnt <= 0.
  - If s == f: cnt <= 0, so a shorter glitch is discarded.
  - FILTER_CYCLES of 0 or 1: f <= s every cycle.
- Detection: a rise is f going 0->1 this cycle; a fall is f going 1->0. The qualifying edge is gated by mode:
  - 00 = off;
  - 01 = rise only;
  - 10 = fall only;
  - 11 = both.
- Latency: if in_sig changes and is first sampled at edge k, edge_out goes high after edge k + SYNC_STAGES + max(FILTER_CYCLES,1) and stays high PULSE_WIDTH cycles.
- Stretch:
  - A qualifying edge loads the pulse counter with PULSE_WIDTH; edge_out = (counter != 0).
  - edge_is_rise is captured on the qualifying edge.
  - An edge arriving while a pulse is active reloads the counter and updates edge_is_rise (retrigger, no gap).
- enable=0:
  - synchroniser and filter keep tracking;
  - no new pulses or flags are generated;
  - an active pulse completes;
  - flags hold.
- A mode change takes effect on the next cycle's detection and does not truncate an active pulse.
- Flags:
  - set on a qualifying edge;
  - cleared by clr_flag on the next edge;
  - a set and a clear in the same cycle leave the flag at 1 (set wins).
- irq = |edge_flag, driven from registers with no extra latency.
- Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.

Decomposition:
- Package multi_edge_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - a clog2-style width helper for the counters.
- Sub-module edge_channel holds one channel's synchroniser, filter, detect, stretch and flag logic. The top generate-instantiates CHANNELS copies and ORs the flags into irq.

Test Plan (CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3, PULSE_WIDTH=2, INIT_LEVEL=0):
- Reset: hold rst=0 with in_sig=4'hF → edge_out, edge_flag, edge_is_rise and irq all 0. Release with mode=all 11 and enable=1 → every channel pulses with edge_is_rise=1 exactly 5 cycles after the first sampling edge.
- Rise-only: set mode[1:0]=01 and in_sig[0] 0->1 sampled at edge k → edge_out[0]=1 after edges k+5 and k+6, then 0; edge_is_rise[0]=1; edge_flag[0]=1; irq=1. The later 1->0 on in_sig[0] produces no pulse.
- Glitch: with mode[3:2]=11, in_sig[1] high for 2 cycles → no pulse and no flag. The same input high for 3 cycles → one rise pulse. The 1->0 transition after it → one fall pulse with edge_is_rise[1]=0.
- Retrigger: with PULSE_WIDTH=4 and FILTER_CYCLES=0, toggle in_sig[2] every 2 cycles → edge_out[2] stays continuously high and edge_is_rise[2] alternates.
- Flags: assert clr_flag[0] in the same cycle a new ch0 edge sets the flag → edge_flag[0] stays 1. Assert clr_flag[0] alone → edge_flag[0]=0 next cycle and irq=0 if no other flag is set.
- Enable and reset: an edge while enable=0 → no pulse and no flag. Assert rst=0 mid-pulse → edge_out drops in the same cycle, without waiting for a clock edge.
